biu_arbiter: RTL and testbench

BIU_ARBITER -- requirements
Module: biu_arbiter

---
 rtl/biu_arbiter.sv | 91 +++++++++
 tb/tb_biu_arbiter.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/biu_arbiter.sv
// biu_arbiter: round-robin bus arbiter with registered one-hot grant, turnaround gap and tenure timeout
module biu_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int ID_WIDTH       = $clog2(NUM_MASTERS)
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic [NUM_MASTERS-1:0] i_req,
  output logic [NUM_MASTERS-1:0] o_grant,
  output logic [ID_WIDTH-1:0]    o_grant_id,
  output logic                   o_busy,
  output logic                   o_timeout
);
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;
  state_t state, state_n;
  logic [NUM_MASTERS-1:0] lockout, lock_n, elig, grant_n;
  logic [ID_WIDTH-1:0] last_owner, last_n, id_n, win, idx;
  logic [CW-1:0] cnt, cnt_n;
  logic found, to_n;
  assign elig = i_req & ~lockout;
  // rotating-priority search starting just above the most recent owner
  always_comb begin
    win = '0;
    idx = '0;
    found = 1'b0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      idx = ID_WIDTH'((int'(last_owner) + i) % NUM_MASTERS);
      if (!found && elig[idx]) begin
        win = idx;
        found = 1'b1;
      end
    end
  end
  // next-state and next-output logic; every output is registered below
  always_comb begin
    state_n = state;
    grant_n = o_grant;
    id_n    = o_grant_id;
    last_n  = last_owner;
    cnt_n   = cnt;
    to_n    = 1'b0;
    lock_n  = lockout & i_req;
    if (state == GRANT) begin
      if (!i_req[o_grant_id]) begin
        state_n = TURN;
        grant_n = '0;
      end else if (TIMEOUT_CYCLES != 0 && cnt == CW'(TIMEOUT_CYCLES)) begin
        state_n = TURN;
        grant_n = '0;
        to_n    = 1'b1;
        lock_n[o_grant_id] = 1'b1;
      end else begin
        cnt_n = (cnt == '1) ? cnt : cnt + 1'b1;
      end
    end else if (found) begin
      state_n = GRANT;
      grant_n = '0;
      grant_n[win] = 1'b1;
      id_n    = win;
      last_n  = win;
      cnt_n   = CW'(1);
    end else begin
      state_n = IDLE;
      grant_n = '0;
    end
  end
  // state and output registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      o_grant    <= '0;
      o_grant_id <= '0;
      o_busy     <= 1'b0;
      o_timeout  <= 1'b0;
      lockout    <= '0;
      cnt        <= '0;
      last_owner <= ID_WIDTH'(NUM_MASTERS - 1);
    end else begin
      state      <= state_n;
      o_grant    <= grant_n;
      o_grant_id <= id_n;
      o_busy     <= |grant_n;
      o_timeout  <= to_n;
      lockout    <= lock_n;
      cnt        <= cnt_n;
      last_owner <= last_n;
    end
  end
endmodule

// File: tb/tb_biu_arbiter.sv
// tb_biu_arbiter: directed vector table plus hand sequences for timeout, release-at-limit and async reset
module tb_biu_arbiter;
  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic [3:0] i_req = '0;
  logic [3:0] o_grant;
  logic [1:0] o_grant_id;
  logic o_busy, o_timeout;
  int checks = 0;
  int failures = 0;
  typedef struct {
    logic [3:0] req;
    logic [3:0] g;
    logic [1:0] id;
    logic       busy;
    logic       to;
  } vec_t;
  vec_t v[21];
  biu_arbiter #(.NUM_MASTERS(4), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .n_rst(n_rst), .i_req(i_req),
    .o_grant(o_grant), .o_grant_id(o_grant_id), .o_busy(o_busy), .o_timeout(o_timeout)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic do_reset();
    n_rst = 1'b0;
    i_req = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_grant", o_grant, 0);
    chk("rst_id", o_grant_id, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_timeout", o_timeout, 0);
    n_rst = 1'b1;
  endtask
  task automatic step(input logic [3:0] r);
    i_req = r;
    @(posedge clk);
    #1;
  endtask
  initial begin
    int gcnt, tcnt;
    v[0]  = '{4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0};
    v[1]  = '{4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0};
    v[2]  = '{4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
    v[3]  = '{4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
    v[4]  = '{4'b1111, 4'b0010, 2'd1, 1'b1, 1'b0};
    v[5]  = '{4'b1101, 4'b0000, 2'd1, 1'b0, 1'b0};
    v[6]  = '{4'b1101, 4'b0100, 2'd2, 1'b1, 1'b0};
    v[7]  = '{4'b1001, 4'b0000, 2'd2, 1'b0, 1'b0};
    v[8]  = '{4'b1001, 4'b1000, 2'd3, 1'b1, 1'b0};
    v[9]  = '{4'b0001, 4'b0000, 2'd3, 1'b0, 1'b0};
    v[10] = '{4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0};
    v[11] = '{4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0};
    v[12] = '{4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
    v[13] = '{4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0};
    v[14] = '{4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0};
    v[15] = '{4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0};
    v[16] = '{4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0};
    v[17] = '{4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0};
    v[18] = '{4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0};
    v[19] = '{4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0};
    v[20] = '{4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0};
    do_reset();
    for (int i = 0; i < 21; i++) begin
      step(v[i].req);
      chk($sformatf("vec%0d_grant", i), o_grant, v[i].g);
      chk($sformatf("vec%0d_id", i), o_grant_id, v[i].id);
      chk($sformatf("vec%0d_busy", i), o_busy, v[i].busy);
      chk($sformatf("vec%0d_timeout", i), o_timeout, v[i].to);
    end
    // all four request together: 0,1,2,3,0 with one gap cycle between tenures
    do_reset();
    step(4'b1111);
    chk("rr_first", o_grant, 4'b0001);
    step(4'b1110);
    chk("rr_gap0", o_grant, 4'b0000);
    step(4'b1111);
    chk("rr_second", o_grant, 4'b0010);
    step(4'b1101);
    step(4'b1111);
    chk("rr_third", o_grant, 4'b0100);
    step(4'b1011);
    step(4'b1111);
    chk("rr_fourth", o_grant, 4'b1000);
    step(4'b0111);
    step(4'b1111);
    chk("rr_wrap", o_grant, 4'b0001);
    chk("rr_wrap_id", o_grant_id, 0);
    // master 1 held for 20 cycles: 8 grant cycles, one timeout pulse, then locked out
    do_reset();
    gcnt = 0;
    tcnt = 0;
    for (int i = 0; i < 20; i++) begin
      step(4'b0010);
      if (o_grant == 4'b0010) gcnt++;
      if (o_timeout) tcnt++;
      if (i == 8) chk("to_pulse_cycle", o_timeout, 1);
    end
    chk("to_grant_cycles", gcnt, 8);
    chk("to_pulses", tcnt, 1);
    chk("to_locked_grant", o_grant, 0);
    step(4'b0000);
    chk("to_drop_grant", o_grant, 0);
    step(4'b0010);
    chk("to_regrant", o_grant, 4'b0010);
    chk("to_regrant_id", o_grant_id, 1);
    // master 3 releases on its 8th grant cycle while master 0 waits
    do_reset();
    step(4'b1000);
    chk("rel_grant", o_grant, 4'b1000);
    for (int i = 0; i < 7; i++) step(4'b1001);
    chk("rel_still", o_grant, 4'b1000);
    step(4'b0001);
    chk("rel_turn_grant", o_grant, 0);
    chk("rel_no_timeout", o_timeout, 0);
    step(4'b0001);
    chk("rel_next_grant", o_grant, 4'b0001);
    chk("rel_next_id", o_grant_id, 0);
    // reset asserted mid-tenure drops the grant without waiting for a clock
    do_reset();
    step(4'b0100);
    chk("ar_grant", o_grant, 4'b0100);
    #2;
    n_rst = 1'b0;
    #1;
    chk("ar_async_grant", o_grant, 0);
    chk("ar_async_busy", o_busy, 0);
    i_req = 4'b0110;
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    step(4'b0110);
    chk("ar_first_grant", o_grant, 4'b0010);
    chk("ar_first_id", o_grant_id, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
